// File: rtl/px_skip_if.sv
// Pixel-skipper configuration bus from the CSR block: keep/skip/add-interval
// fields for the pixel axis and the line axis.
interface px_skip_if;
    logic [7:0] px_to_skip;
    logic [7:0] px_interval;
    logic [7:0] px_add_interval;
    logic [7:0] ln_to_skip;
    logic [7:0] ln_interval;
    logic [7:0] ln_add_interval;

    modport master (
        output px_to_skip, px_interval, px_add_interval,
        output ln_to_skip, ln_interval, ln_add_interval
    );

    modport slave (
        input px_to_skip, px_interval, px_add_interval,
        input ln_to_skip, ln_interval, ln_add_interval
    );
endinterface

// File: rtl/px_skip_sched.sv
// Per-beat keep/drop scheduler for the pixel skipper (pixel and line axes).
// Optional PX_SKIP_SCHED_STAT_EN adds stat_o: dropped-beat count of the previous frame.
module px_skip_sched #(
    parameter int unsigned CNT_W = 9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    px_skip_if.slave   px_skip_i,
    input  logic       tvalid_i,
    input  logic       tready_i,
    input  logic       tuser_i,
    input  logic       tlast_i,
    output logic       keep_o,
    output logic       px_keep_o,
    output logic       ln_keep_o,
`ifdef PX_SKIP_SCHED_STAT_EN
    output logic [15:0] stat_o,
`endif
    output logic       cfg_applied_o
);

    localparam int unsigned CFG_W  = 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic { FRM_WAIT_SOF, FRM_RUN } frm_state_e;
    typedef enum logic { AX_KEEP, AX_SKIP } ax_state_e;

    typedef struct packed {
        logic [CFG_W-1:0] sk;
        logic [CFG_W-1:0] iv;
        logic [CFG_W-1:0] ad;
    } ax_cfg_t;

    typedef struct packed {
        ax_state_e        st;
        logic [CNT_W-1:0] run;
        logic [CNT_W-1:0] per;
    } ax_t;

    localparam ax_t AX_FRESH = '{st: AX_KEEP, run: '0, per: '0};

    // One step of an axis: keep klen units, skip sk units, stretch every ad-th keep run.
    function automatic ax_t axis_step(input ax_t a, input ax_cfg_t c);
        ax_t              n;
        logic [CNT_W-1:0] ad_w;
        logic [CNT_W-1:0] sk_w;
        logic [CNT_W-1:0] klen;
        logic [CNT_W-1:0] per_nx;
        logic             long_run;
        n        = a;
        ad_w     = CNT_W'(c.ad);
        sk_w     = CNT_W'(c.sk);
        long_run = (c.ad != '0) && (a.per == ad_w - CNT_W'(1));
        klen     = CNT_W'(c.iv) + (long_run ? CNT_W'(1) : CNT_W'(0));
        per_nx   = ((c.ad == '0) || long_run) ? '0 : a.per + CNT_W'(1);
        if (a.st == AX_KEEP) begin
            if (a.run == klen - CNT_W'(1)) begin
                n.run = '0;
                if (c.sk != '0) begin
                    n.st = AX_SKIP;
                end else begin
                    n.per = per_nx;
                end
            end else begin
                n.run = a.run + CNT_W'(1);
            end
        end else begin
            if (a.run == sk_w - CNT_W'(1)) begin
                n.run = '0;
                n.st  = AX_KEEP;
                n.per = per_nx;
            end else begin
                n.run = a.run + CNT_W'(1);
            end
        end
        return n;
    endfunction

    frm_state_e frm_q, frm_d;
    ax_cfg_t    px_cfg_q, px_cfg_d;
    ax_cfg_t    ln_cfg_q, ln_cfg_d;
    ax_t        px_ax_q, px_ax_d;
    ax_t        ln_ax_q, ln_ax_d;
    logic       cfg_applied_q, cfg_applied_d;

    logic       beat;
    logic       sof_beat;
    logic       eol_beat;
    ax_cfg_t    px_cfg_in;
    ax_cfg_t    ln_cfg_in;

    assign beat     = tvalid_i & tready_i;
    assign sof_beat = beat & tuser_i;
    assign eol_beat = beat & tlast_i;

    // Incoming config with interval clamped to at least one kept unit.
    always_comb begin
        px_cfg_in.sk = px_skip_i.px_to_skip;
        px_cfg_in.iv = (px_skip_i.px_interval == '0) ? CFG_W'(1) : px_skip_i.px_interval;
        px_cfg_in.ad = px_skip_i.px_add_interval;
        ln_cfg_in.sk = px_skip_i.ln_to_skip;
        ln_cfg_in.iv = (px_skip_i.ln_interval == '0) ? CFG_W'(1) : px_skip_i.ln_interval;
        ln_cfg_in.ad = px_skip_i.ln_add_interval;
    end

    // Frame FSM and axis next-state; SOF reload wins over EOL on the same beat.
    always_comb begin
        frm_d         = frm_q;
        px_cfg_d      = px_cfg_q;
        ln_cfg_d      = ln_cfg_q;
        px_ax_d       = px_ax_q;
        ln_ax_d       = ln_ax_q;
        cfg_applied_d = 1'b0;

        if (sof_beat) begin
            frm_d         = FRM_RUN;
            px_cfg_d      = px_cfg_in;
            ln_cfg_d      = ln_cfg_in;
            cfg_applied_d = 1'b1;
            px_ax_d       = axis_step(AX_FRESH, px_cfg_in);
            ln_ax_d       = eol_beat ? axis_step(AX_FRESH, ln_cfg_in) : AX_FRESH;
        end else if (beat && (frm_q == FRM_RUN)) begin
            px_ax_d = axis_step(px_ax_q, px_cfg_q);
            if (eol_beat) begin
                ln_ax_d = axis_step(ln_ax_q, ln_cfg_q);
            end
        end

        if (eol_beat) begin
            px_ax_d = AX_FRESH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            frm_q         <= FRM_WAIT_SOF;
            px_cfg_q      <= '0;
            ln_cfg_q      <= '0;
            px_ax_q       <= AX_FRESH;
            ln_ax_q       <= AX_FRESH;
            cfg_applied_q <= 1'b0;
        end else begin
            frm_q         <= frm_d;
            px_cfg_q      <= px_cfg_d;
            ln_cfg_q      <= ln_cfg_d;
            px_ax_q       <= px_ax_d;
            ln_ax_q       <= ln_ax_d;
            cfg_applied_q <= cfg_applied_d;
        end
    end

    // The SOF beat is always kept, even before the first frame has started.
    assign px_keep_o     = (px_ax_q.st == AX_KEEP) | tuser_i;
    assign ln_keep_o     = (ln_ax_q.st == AX_KEEP) | tuser_i;
    assign keep_o        = px_keep_o & ln_keep_o & ((frm_q == FRM_RUN) | tuser_i);
    assign cfg_applied_o = cfg_applied_q;

`ifdef PX_SKIP_SCHED_STAT_EN
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [STAT_W-1:0] stat_q, stat_d;

    // Saturating drop counter, published and cleared at every SOF beat.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        stat_d     = stat_q;
        if (sof_beat) begin
            stat_d     = drop_cnt_q;
            drop_cnt_d = '0;
        end else if (beat && (frm_q == FRM_RUN) && !keep_o && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            drop_cnt_q <= '0;
            stat_q     <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            stat_q     <= stat_d;
        end
    end

    assign stat_o = stat_q;
`endif

endmodule

// File: tb/tb_px_skip_sched.sv
// Directed self-checking bench for px_skip_sched: expected keep_o per beat is
// queued as each beat is driven and compared when the beat is observed.
module tb_px_skip_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;
    logic tvalid_i;
    logic tready_i;
    logic tuser_i;
    logic tlast_i;
    logic keep_o;
    logic px_keep_o;
    logic ln_keep_o;
    logic cfg_applied_o;
`ifdef PX_SKIP_SCHED_STAT_EN
    logic [15:0] stat_o;
`endif

    px_skip_if cfg ();

    px_skip_sched dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .px_skip_i     (cfg),
        .tvalid_i      (tvalid_i),
        .tready_i      (tready_i),
        .tuser_i       (tuser_i),
        .tlast_i       (tlast_i),
        .keep_o        (keep_o),
        .px_keep_o     (px_keep_o),
        .ln_keep_o     (ln_keep_o),
`ifdef PX_SKIP_SCHED_STAT_EN
        .stat_o        (stat_o),
`endif
        .cfg_applied_o (cfg_applied_o)
    );

    int checks = 0;
    int errors = 0;
    int applied_cnt = 0;
    bit exp_q[$];

    always @(negedge clk) if (cfg_applied_o === 1'b1) applied_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int psk, input int piv, input int pad,
                           input int lsk, input int liv, input int lad);
        cfg.px_to_skip      = 8'(psk);
        cfg.px_interval     = 8'(piv);
        cfg.px_add_interval = 8'(pad);
        cfg.ln_to_skip      = 8'(lsk);
        cfg.ln_interval     = 8'(liv);
        cfg.ln_add_interval = 8'(lad);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            tvalid_i = 1'b0;
            tready_i = 1'b1;
            tuser_i  = 1'b0;
            tlast_i  = 1'b0;
        end
    endtask

    // One line of n beats; pat[i] is the expected keep_o of beat i; optional 5-cycle stall.
    task automatic line(input string tag, input int n, input bit sof,
                        input logic [31:0] pat, input int stall_at);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    tvalid_i = 1'b1;
                    tready_i = 1'b0;
                    tuser_i  = 1'b0;
                    tlast_i  = 1'b0;
                    @(negedge clk);
                    check($sformatf("%s_stall%0d", tag, k), 32'(keep_o), 32'(pat[i]));
                end
            end
            @(posedge clk);
            #1;
            tvalid_i = 1'b1;
            tready_i = 1'b1;
            tuser_i  = sof && (i == 0);
            tlast_i  = (i == n - 1);
            exp_q.push_back(pat[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("%s_sb_empty%0d", tag, i), 32'(1), 32'(0));
            end else begin
                check($sformatf("%s_px%0d", tag, i), 32'(keep_o), 32'(exp_q.pop_front()));
            end
        end
        idle(1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst_i    = 1'b0;
        tvalid_i = 1'b0;
        tready_i = 1'b1;
        tuser_i  = 1'b0;
        tlast_i  = 1'b0;
        set_cfg(0, 1, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_keep", 32'(keep_o), 32'(0));
        check("rst_px_keep", 32'(px_keep_o), 32'(1));
        check("rst_ln_keep", 32'(ln_keep_o), 32'(1));
        check("rst_applied", 32'(cfg_applied_o), 32'(0));
`ifdef PX_SKIP_SCHED_STAT_EN
        check("rst_stat", 32'(stat_o), 32'(0));
`endif
        rst_i = 1'b1;
        idle(2);

        // Alternate keep/drop; next line restarts with a kept pixel.
        set_cfg(1, 1, 0, 0, 1, 0);
        a0 = applied_cnt;
        line("t1_l0", 8, 1'b1, 32'h55, -1);
        line("t1_l1", 8, 1'b0, 32'h55, -1);
        check("t1_applied", 32'(applied_cnt), 32'(a0 + 1));

        // Fractional ratio: every second keep run is one pixel longer.
        set_cfg(1, 2, 2, 0, 1, 0);
        line("t2", 12, 1'b1, 32'hDBB, -1);

        // Line axis: keep one line, skip two.
        set_cfg(0, 1, 0, 2, 1, 0);
        line("t3_l0", 4, 1'b1, 32'hF, -1);
        line("t3_l1", 4, 1'b0, 32'h0, -1);
        line("t3_l2", 4, 1'b0, 32'h0, -1);
        line("t3_l3", 4, 1'b0, 32'hF, -1);

        // Mid-frame config write is ignored until the next SOF.
        set_cfg(1, 1, 0, 0, 1, 0);
        a0 = applied_cnt;
        line("t4_l0", 8, 1'b1, 32'h55, -1);
        set_cfg(3, 1, 0, 0, 1, 0);
        line("t4_l1", 8, 1'b0, 32'h55, -1);
        check("t4_no_pulse", 32'(applied_cnt), 32'(a0 + 1));
        line("t4_new", 8, 1'b1, 32'h11, -1);
        check("t4_one_pulse", 32'(applied_cnt), 32'(a0 + 2));

        // Stall holds state and keep_o.
        set_cfg(1, 1, 0, 0, 1, 0);
        line("t5", 8, 1'b1, 32'h55, 4);

        // Zero interval behaves as one.
        set_cfg(1, 0, 0, 0, 1, 0);
        line("iv0", 6, 1'b1, 32'h15, -1);

        // One-pixel SOF+EOL line: reload, then line axis advances once.
        set_cfg(0, 1, 0, 1, 1, 0);
        line("sol_l0", 1, 1'b1, 32'h1, -1);
        line("sol_l1", 2, 1'b0, 32'h0, -1);
        line("sol_l2", 2, 1'b0, 32'h3, -1);

        // Reset mid-frame drops beats until the next SOF.
        set_cfg(1, 1, 0, 0, 1, 0);
        line("t6_pre", 3, 1'b1, 32'h5, -1);
        rst_i = 1'b0;
        idle(2);
        rst_i = 1'b1;
        @(negedge clk);
        check("t6_rst_applied", 32'(cfg_applied_o), 32'(0));
        line("t6_wait", 3, 1'b0, 32'h0, -1);
        line("t6_f_l0", 4, 1'b1, 32'h5, -1);
        line("t6_f_l1", 4, 1'b0, 32'h5, -1);
        line("t6_f_l2", 4, 1'b0, 32'h5, -1);
        line("t6_f_l3", 4, 1'b0, 32'h5, -1);
        line("t6_sof2", 1, 1'b1, 32'h1, -1);
`ifdef PX_SKIP_SCHED_STAT_EN
        check("t6_stat", 32'(stat_o), 32'(8));
`endif
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
